// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-ported backing memory.
// Port 0 is the data port (loads/stores) and port 1 the instruction-fetch port. One access
// is in flight at a time: IDLE selects a port, WAIT holds the memory request until the
// memory acks or the wait budget runs out, and RESP issues a one-cycle ack to the owner.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_0/i_addr_0/i_wdata_0/  data-port request, held until o_ack_0
//   i_we_0/i_be_0
//   i_req_1/i_addr_1             fetch-port request, held until o_ack_1
//   o_rdata_0/o_ack_0            data-port response (o_rdata_0 valid with o_ack_0)
//   o_rdata_1/o_ack_1            fetch-port response (o_rdata_1 valid with o_ack_1)
//   o_err                        qualifies the current ack: misaligned or timed out
//   o_busy                       arbiter not in IDLE
//   mem_req/mem_addr/mem_wdata/  memory request, held until i_mem_ack
//   mem_we/mem_be
//   i_mem_rdata/i_mem_ack        memory response, one cycle
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_0,
   input  logic [31:0] i_addr_0,
   input  logic [31:0] i_wdata_0,
   input  logic        i_we_0,
   input  logic [3:0]  i_be_0,
   input  logic        i_req_1,
   input  logic [31:0] i_addr_1,
   output logic [31:0] o_rdata_0,
   output logic        o_ack_0,
   output logic [31:0] o_rdata_1,
   output logic        o_ack_1,
   output logic        o_err,
   output logic        o_busy,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ack
);

   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
   localparam logic [7:0] TmoLast   = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StResp = 2'd2} state_e;

   state_e      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [7:0]  tmo_q, tmo_d;
   logic        port_q, port_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic        ack_0_q, ack_0_d;
   logic        ack_1_q, ack_1_d;
   logic        err_q, err_d;
   logic [31:0] rdata_0_q, rdata_0_d;
   logic [31:0] rdata_1_q, rdata_1_d;

   logic        any_req;
   logic        sel_port;
   logic [31:0] sel_addr;
   logic        sel_misaligned;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_data;

   // Port selection for a grant in IDLE; port 0 wins a tie unless port 1 has starved.
   always_comb begin
      any_req = i_req_0 | i_req_1;
      if (i_req_0 && i_req_1) begin
         sel_port = (starve_q == StarveMax);
      end else begin
         sel_port = i_req_1;
      end
      sel_addr       = sel_port ? i_addr_1 : i_addr_0;
      sel_misaligned = (sel_addr[1:0] != 2'b00);
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d = sel_misaligned ? StResp : StWait;
            end
         end
         StWait: begin
            if (i_mem_ack || (tmo_q == TmoLast)) begin
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic: next values of the registered outputs and counters.
   always_comb begin
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      port_d      = port_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      ack_0_d     = 1'b0;
      ack_1_d     = 1'b0;
      err_d       = 1'b0;
      rdata_0_d   = rdata_0_q;
      rdata_1_d   = rdata_1_q;
      resp_valid  = 1'b0;
      resp_err    = 1'b0;
      resp_data   = '0;

      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               port_d = sel_port;
               if (sel_port) begin
                  starve_d = '0;
               end else if (i_req_1 && (starve_q != StarveMax)) begin
                  starve_d = starve_q + 4'd1;
               end
               if (sel_misaligned) begin
                  // Never reaches memory; answered straight from IDLE.
                  resp_valid = 1'b1;
                  resp_err   = 1'b1;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_addr_d  = sel_addr;
                  mem_wdata_d = sel_port ? 32'd0 : i_wdata_0;
                  mem_we_d    = ~sel_port & i_we_0;
                  mem_be_d    = sel_port ? 4'hF : i_be_0;
                  tmo_d       = '0;
               end
            end
         end
         StWait: begin
            // An ack in the last allowed cycle still completes normally.
            if (i_mem_ack) begin
               mem_req_d  = 1'b0;
               resp_valid = 1'b1;
               resp_data  = mem_we_q ? 32'd0 : i_mem_rdata;
            end else if (tmo_q == TmoLast) begin
               mem_req_d  = 1'b0;
               resp_valid = 1'b1;
               resp_err   = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         default: ;
      endcase

      if (resp_valid) begin
         err_d = resp_err;
         if (port_d) begin
            ack_1_d   = 1'b1;
            rdata_1_d = resp_data;
         end else begin
            ack_0_d   = 1'b1;
            rdata_0_d = resp_data;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         starve_q    <= '0;
         tmo_q       <= '0;
         port_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         ack_0_q     <= 1'b0;
         ack_1_q     <= 1'b0;
         err_q       <= 1'b0;
         rdata_0_q   <= '0;
         rdata_1_q   <= '0;
      end else begin
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         port_q      <= port_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         ack_0_q     <= ack_0_d;
         ack_1_q     <= ack_1_d;
         err_q       <= err_d;
         rdata_0_q   <= rdata_0_d;
         rdata_1_q   <= rdata_1_d;
      end
   end

   assign o_busy    = (state_q != StIdle);
   assign o_ack_0   = ack_0_q;
   assign o_ack_1   = ack_1_q;
   assign o_err     = err_q;
   assign o_rdata_0 = rdata_0_q;
   assign o_rdata_1 = rdata_1_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized traffic checked
// against a transaction-level model (grant order from the starvation rule, memory array).
module tb_mem_arbiter;

   localparam int unsigned STARVE_LIMIT = 4;
   localparam int unsigned TIMEOUT      = 16;

   typedef struct {
      bit          port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  be;
   } op_t;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_req_0 = 1'b0;
   logic [31:0] i_addr_0 = '0;
   logic [31:0] i_wdata_0 = '0;
   logic        i_we_0 = 1'b0;
   logic [3:0]  i_be_0 = '0;
   logic        i_req_1 = 1'b0;
   logic [31:0] i_addr_1 = '0;
   logic [31:0] i_mem_rdata = '0;
   logic        i_mem_ack = 1'b0;
   logic [31:0] o_rdata_0, o_rdata_1, mem_addr, mem_wdata;
   logic        o_ack_0, o_ack_1, o_err, o_busy, mem_req, mem_we;
   logic [3:0]  mem_be;

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;
   logic [31:0] mem [64];

   always #5 clk = ~clk;

   mem_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_req_0    (i_req_0),
      .i_addr_0   (i_addr_0),
      .i_wdata_0  (i_wdata_0),
      .i_we_0     (i_we_0),
      .i_be_0     (i_be_0),
      .i_req_1    (i_req_1),
      .i_addr_1   (i_addr_1),
      .o_rdata_0  (o_rdata_0),
      .o_ack_0    (o_ack_0),
      .o_rdata_1  (o_rdata_1),
      .o_ack_1    (o_ack_1),
      .o_err      (o_err),
      .o_busy     (o_busy),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .i_mem_rdata(i_mem_rdata),
      .i_mem_ack  (i_mem_ack)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({o_rdata_0, o_ack_0, o_rdata_1, o_ack_1, o_err, o_busy, mem_req, mem_addr, mem_wdata,
           mem_we, mem_be} !== '0)
         $display("FAIL reset_outputs: got rd0=%h a0=%b rd1=%h a1=%b err=%b busy=%b req=%b, required all 0",
                  o_rdata_0, o_ack_0, o_rdata_1, o_ack_1, o_err, o_busy, mem_req);
      else pass_cnt++;
      i_rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({o_busy, mem_req, o_ack_0, o_ack_1} !== 4'b0000)
         $display("FAIL reset_release_idle: got busy/req/a0/a1=%b, required 0000",
                  {o_busy, mem_req, o_ack_0, o_ack_1});
      else pass_cnt++;
   endtask

   task automatic test_single_fetch();
      i_req_1  = 1'b1;
      i_addr_1 = 32'h100;
      @(negedge clk);
      total_cnt++;
      if ({mem_req, mem_addr, mem_we, mem_be, o_busy, o_ack_1} !== {1'b1, 32'h100, 1'b0, 4'hF, 1'b1, 1'b0})
         $display("FAIL fetch_mem_issue: got req=%b addr=%h we=%b be=%h busy=%b, required 1 100 0 f 1",
                  mem_req, mem_addr, mem_we, mem_be, o_busy);
      else pass_cnt++;
      i_mem_ack   = 1'b1;
      i_mem_rdata = 32'h00500093;
      @(negedge clk);
      i_mem_ack = 1'b0;
      i_req_1   = 1'b0;
      total_cnt++;
      if ({o_ack_1, o_ack_0, o_err, o_rdata_1, mem_req} !== {3'b100, 32'h00500093, 1'b0})
         $display("FAIL fetch_ack: got a1=%b a0=%b err=%b rd1=%h req=%b, required 1 0 0 00500093 0",
                  o_ack_1, o_ack_0, o_err, o_rdata_1, mem_req);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({o_busy, o_ack_1} !== 2'b00)
         $display("FAIL fetch_return_idle: got busy=%b a1=%b, required 0 0", o_busy, o_ack_1);
      else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      i_req_0 = 1'b1; i_addr_0 = 32'h200; i_wdata_0 = 32'hDEADBEEF; i_we_0 = 1'b1; i_be_0 = 4'b0011;
      i_req_1 = 1'b1; i_addr_1 = 32'h104;
      @(negedge clk);
      total_cnt++;
      if ({mem_req, mem_addr, mem_wdata, mem_we, mem_be} !== {1'b1, 32'h200, 32'hDEADBEEF, 1'b1, 4'b0011})
         $display("FAIL simul_store_issue: got req=%b addr=%h wd=%h we=%b be=%b, required 1 200 deadbeef 1 0011",
                  mem_req, mem_addr, mem_wdata, mem_we, mem_be);
      else pass_cnt++;
      i_mem_ack = 1'b1; i_mem_rdata = 32'h55555555;
      @(negedge clk);
      i_mem_ack = 1'b0; i_req_0 = 1'b0; i_we_0 = 1'b0;
      total_cnt++;
      if ({o_ack_0, o_ack_1, o_err, o_rdata_0, o_rdata_1} !== {3'b100, 32'h0, 32'h00500093})
         $display("FAIL simul_store_ack: got a0=%b a1=%b err=%b rd0=%h rd1=%h, required 1 0 0 0 00500093",
                  o_ack_0, o_ack_1, o_err, o_rdata_0, o_rdata_1);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({mem_req, mem_addr, mem_we, mem_be} !== {1'b1, 32'h104, 1'b0, 4'hF})
         $display("FAIL simul_fetch_issue: got req=%b addr=%h we=%b be=%h, required 1 104 0 f",
                  mem_req, mem_addr, mem_we, mem_be);
      else pass_cnt++;
      i_mem_ack = 1'b1; i_mem_rdata = 32'h12345678;
      @(negedge clk);
      i_mem_ack = 1'b0; i_req_1 = 1'b0;
      total_cnt++;
      if ({o_ack_1, o_ack_0, o_err, o_rdata_1} !== {3'b100, 32'h12345678})
         $display("FAIL simul_fetch_ack: got a1=%b a0=%b err=%b rd1=%h, required 1 0 0 12345678",
                  o_ack_1, o_ack_0, o_err, o_rdata_1);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_starvation();
      int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int n = 0;
      int got;
      i_req_0 = 1'b1; i_addr_0 = 32'h10; i_we_0 = 1'b0; i_be_0 = 4'hF;
      i_req_1 = 1'b1; i_addr_1 = 32'h20;
      for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
         @(negedge clk);
         i_mem_ack = 1'b0;
         if (o_ack_0 || o_ack_1) begin
            got = o_ack_1 ? 1 : 0;
            total_cnt++;
            if (got != exp_seq[n] || (o_ack_0 && o_ack_1))
               $display("FAIL starve_grant_%0d: got port %0d (a0=%b a1=%b), required port %0d",
                        n, got, o_ack_0, o_ack_1, exp_seq[n]);
            else pass_cnt++;
            n++;
            if (o_ack_1) i_addr_1 = 32'h20 + 32'(n * 4);
            else i_addr_0 = 32'h10 + 32'(n * 4);
         end
         if (mem_req) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = 32'hA5A50000 | 32'(n + 1);
         end
      end
      total_cnt++;
      if (n != 10) $display("FAIL starve_count: got %0d grants, required 10", n);
      else pass_cnt++;
      i_req_0 = 1'b0; i_req_1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int wc = 0;
      i_req_0 = 1'b1; i_addr_0 = 32'h300; i_we_0 = 1'b0; i_be_0 = 4'hF;
      @(negedge clk);
      while (mem_req && wc < 40) begin
         wc++;
         @(negedge clk);
      end
      i_req_0 = 1'b0;
      total_cnt++;
      if (wc != int'(TIMEOUT)) $display("FAIL timeout_wait_cycles: got %0d, required %0d", wc, TIMEOUT);
      else pass_cnt++;
      total_cnt++;
      if ({o_ack_0, o_ack_1, o_err, o_rdata_0} !== {3'b101, 32'h0})
         $display("FAIL timeout_ack: got a0=%b a1=%b err=%b rd0=%h, required 1 0 1 0",
                  o_ack_0, o_ack_1, o_err, o_rdata_0);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({o_busy, o_ack_0, o_err} !== 3'b000)
         $display("FAIL timeout_idle: got busy=%b a0=%b err=%b, required 0 0 0", o_busy, o_ack_0, o_err);
      else pass_cnt++;
   endtask

   task automatic test_reset_in_wait();
      int seen = 0;
      i_req_1 = 1'b1; i_addr_1 = 32'h40;
      repeat (3) begin
         @(negedge clk);
         if (mem_req) seen++;
      end
      total_cnt++;
      if (seen != 3) $display("FAIL rstwait_in_wait: got %0d wait cycles, required 3", seen);
      else pass_cnt++;
      i_rst = 1'b1; i_req_1 = 1'b0;
      @(negedge clk);
      i_rst = 1'b0;
      total_cnt++;
      if ({mem_req, o_busy, o_ack_0, o_ack_1} !== 4'b0000)
         $display("FAIL rstwait_abort: got req/busy/a0/a1=%b, required 0000",
                  {mem_req, o_busy, o_ack_0, o_ack_1});
      else pass_cnt++;
      i_mem_ack = 1'b1; i_mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      i_mem_ack = 1'b0;
      total_cnt++;
      if ({mem_req, o_busy, o_ack_0, o_ack_1} !== 4'b0000)
         $display("FAIL rstwait_stray_ack: got req/busy/a0/a1=%b, required 0000",
                  {mem_req, o_busy, o_ack_0, o_ack_1});
      else pass_cnt++;
      i_req_0 = 1'b1; i_addr_0 = 32'h44; i_we_0 = 1'b0; i_be_0 = 4'hF;
      @(negedge clk);
      total_cnt++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h44})
         $display("FAIL rstwait_next_issue: got req=%b addr=%h, required 1 44", mem_req, mem_addr);
      else pass_cnt++;
      i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      i_mem_ack = 1'b0; i_req_0 = 1'b0;
      total_cnt++;
      if ({o_ack_0, o_ack_1, o_err, o_rdata_0} !== {3'b100, 32'hCAFEF00D})
         $display("FAIL rstwait_next_ack: got a0=%b a1=%b err=%b rd0=%h, required 1 0 0 cafef00d",
                  o_ack_0, o_ack_1, o_err, o_rdata_0);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_misaligned();
      i_req_0 = 1'b1; i_addr_0 = 32'h203; i_we_0 = 1'b0; i_be_0 = 4'hF;
      @(negedge clk);
      i_req_0 = 1'b0;
      total_cnt++;
      if ({o_ack_0, o_ack_1, o_err, o_rdata_0, mem_req} !== {3'b101, 32'h0, 1'b0})
         $display("FAIL misaligned_ack: got a0=%b a1=%b err=%b rd0=%h req=%b, required 1 0 1 0 0",
                  o_ack_0, o_ack_1, o_err, o_rdata_0, mem_req);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({o_ack_0, o_busy, mem_req} !== 3'b000)
         $display("FAIL misaligned_idle: got a0=%b busy=%b req=%b, required 0 0 0",
                  o_ack_0, o_busy, mem_req);
      else pass_cnt++;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   task automatic test_random();
      op_t         ops0 [$];
      op_t         exp_q [$];
      op_t         op1, o, h;
      int          s = 0;
      int          n0, k, i0, wait_left;
      bit          has1, mem_pending, exp_err;
      logic [31:0] exp_data, got_data;
      for (int w = 0; w < 64; w++) mem[w] = $urandom;
      for (int it = 0; it < 40; it++) begin
         ops0.delete();
         exp_q.delete();
         n0   = $urandom_range(0, 6);
         has1 = 1'($urandom_range(0, 1));
         if (n0 == 0 && !has1) n0 = 1;
         for (int j = 0; j < n0; j++) begin
            o.port = 1'b0; o.addr = rand_addr(); o.wdata = $urandom; o.we = 1'($urandom_range(0, 1));
            o.be = 4'($urandom_range(1, 15));
            ops0.push_back(o);
         end
         op1.port = 1'b1; op1.addr = rand_addr(); op1.wdata = '0; op1.we = 1'b0; op1.be = 4'hF;
         // Port 0 keeps winning until the starvation budget is spent, then port 1 goes.
         if (has1) begin
            k = (n0 < int'(STARVE_LIMIT) - s) ? n0 : int'(STARVE_LIMIT) - s;
            for (int j = 0; j < k; j++) exp_q.push_back(ops0[j]);
            exp_q.push_back(op1);
            for (int j = k; j < n0; j++) exp_q.push_back(ops0[j]);
            s = 0;
         end else begin
            for (int j = 0; j < n0; j++) exp_q.push_back(ops0[j]);
         end
         i0 = 0;
         if (n0 > 0) begin
            i_req_0 = 1'b1; i_addr_0 = ops0[0].addr; i_wdata_0 = ops0[0].wdata;
            i_we_0 = ops0[0].we; i_be_0 = ops0[0].be;
         end
         if (has1) begin
            i_req_1 = 1'b1; i_addr_1 = op1.addr;
         end
         mem_pending = 1'b0;
         wait_left   = 0;
         for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            i_mem_ack = 1'b0;
            if (o_ack_0 || o_ack_1) begin
               h        = exp_q.pop_front();
               exp_err  = (h.addr[1:0] != 2'b00);
               exp_data = (exp_err || h.we) ? 32'h0 : mem[h.addr[7:2]];
               got_data = h.port ? o_rdata_1 : o_rdata_0;
               total_cnt++;
               if ({o_ack_1, o_ack_0} !== (h.port ? 2'b10 : 2'b01) || o_err !== exp_err ||
                   got_data !== exp_data)
                  $display("FAIL random_ack it%0d: got a1a0=%b err=%b data=%h, required port %0d err=%b data=%h",
                           it, {o_ack_1, o_ack_0}, o_err, got_data, h.port, exp_err, exp_data);
               else pass_cnt++;
               if (!exp_err && h.we)
                  for (int b = 0; b < 4; b++)
                     if (h.be[b]) mem[h.addr[7:2]][8*b +: 8] = h.wdata[8*b +: 8];
               if (h.port) begin
                  i_req_1 = 1'b0;
               end else begin
                  i0++;
                  if (i0 < n0) begin
                     i_addr_0 = ops0[i0].addr; i_wdata_0 = ops0[i0].wdata;
                     i_we_0 = ops0[i0].we; i_be_0 = ops0[i0].be;
                  end else begin
                     i_req_0 = 1'b0;
                  end
               end
            end
            if (mem_req && !mem_pending && exp_q.size() > 0) begin
               h = exp_q[0];
               total_cnt++;
               if (h.addr[1:0] != 2'b00 || {mem_addr, mem_we, mem_be} !== {h.addr, h.we, h.be} ||
                   (h.we && mem_wdata !== h.wdata))
                  $display("FAIL random_mem it%0d: got addr=%h we=%b be=%h wd=%h, required addr=%h we=%b be=%h wd=%h",
                           it, mem_addr, mem_we, mem_be, mem_wdata, h.addr, h.we, h.be, h.wdata);
               else pass_cnt++;
               mem_pending = 1'b1;
               wait_left   = $urandom_range(0, 3);
            end
            if (mem_pending) begin
               if (wait_left == 0) begin
                  i_mem_ack   = 1'b1;
                  i_mem_rdata = mem_we ? $urandom : mem[mem_addr[7:2]];
                  mem_pending = 1'b0;
               end else begin
                  wait_left--;
                  i_mem_rdata = $urandom;
               end
            end
         end
         total_cnt++;
         if (exp_q.size() != 0)
            $display("FAIL random_drain it%0d: got %0d outstanding, required 0", it, exp_q.size());
         else pass_cnt++;
         i_req_0 = 1'b0; i_req_1 = 1'b0;
         if (exp_q.size() != 0) break;
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_starvation();
      test_timeout();
      test_reset_in_wait();
      test_misaligned();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
